// File: rtl/sm_ramp_ctrl.sv
// sm_ramp_ctrl -- trapezoidal speed-profile controller for the stepper drive.
//
// Sits upstream of the step-pulse generator and feeds it period words. It
// accelerates from n_start towards n_min, cruises, and decelerates back to
// n_start, so that the move ends after exactly `steps` generator pulses.
//
// Ports
//   clk        system clock (50 MHz)
//   rst        synchronous active-high reset
//   start      one-cycle move request, sampled only while idle
//   abort      one-cycle controlled-stop request, sampled only while busy
//   n_start    slowest period, used at the start and the end of a move
//   n_min      fastest (cruise) period, clamped to n_start
//   n_delta    period change per step while ramping
//   steps      total steps in the move
//   drv_step   step pulse fed back from the generator (rising edge counted)
//   N          period word to the generator
//   d_v        one-cycle strobe, generator latches N on it
//   drv_en_SM  generator enable
//   busy       high while a move is in progress
//   done       one-cycle pulse when a move or an abort completes
//   dbg_state  current FSM state (IDLE=0, ACCEL=1, CRUISE=2, DECEL=3)
//
// Handshake: start/abort are single-cycle requests with no acknowledge; a
// move is acknowledged by busy rising, completion by the one-cycle done.
// d_v is a one-cycle strobe with no back-pressure, issued whenever N changes
// and once at the start of every move.

module sm_ramp_ctrl #(
    parameter int SIZE = 16,
    parameter int CNT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [SIZE-1:0] n_start,
    input  logic [SIZE-1:0] n_min,
    input  logic [SIZE-1:0] n_delta,
    input  logic [CNT-1:0]  steps,
    input  logic            drv_step,
    output logic [SIZE-1:0] N,
    output logic            d_v,
    output logic            drv_en_SM,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEL  = 2'd1,
        S_CRUISE = 2'd2,
        S_DECEL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] n_q, n_d;
    logic            dv_q, dv_d;
    logic            done_q, done_d;
    logic [CNT-1:0]  step_cnt_q, step_cnt_d;
    logic [CNT-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [CNT-1:0]  steps_q, steps_d;
    logic [SIZE-1:0] n_start_q, n_start_d;
    logic [SIZE-1:0] n_min_q, n_min_d;
    logic [SIZE-1:0] n_delta_q, n_delta_d;
    logic            step_d1_q;

    logic            step_ev;
    logic [SIZE-1:0] n_min_eff;
    logic [SIZE-1:0] n_dn;
    logic [CNT-1:0]  rem;
    logic [CNT:0]    target;

    // N + delta, computed one bit wider and clamped to the slow limit.
    function automatic logic [SIZE-1:0] up_clamp(input logic [SIZE-1:0] n,
                                                 input logic [SIZE-1:0] dlt,
                                                 input logic [SIZE-1:0] lim);
        logic [SIZE:0] sum;
        sum = {1'b0, n} + {1'b0, dlt};
        up_clamp = (sum > {1'b0, lim}) ? lim : sum[SIZE-1:0];
    endfunction

    assign n_min_eff = (n_min < n_start) ? n_min : n_start;
    // Saturating N - delta for the acceleration ramp.
    assign n_dn      = (n_q > n_delta_q) ? (n_q - n_delta_q) : '0;
    // The copy of drv_step keeps tracking while idle, so a level that is
    // already high when a move starts is not mistaken for a fresh edge.
    assign step_ev   = drv_step && !step_d1_q && (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        dv_d       = 1'b0;
        done_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        ramp_cnt_d = ramp_cnt_q;
        steps_d    = steps_q;
        n_start_d  = n_start_q;
        n_min_d    = n_min_q;
        n_delta_d  = n_delta_q;
        rem        = '0;
        target     = '0;

        if (state_q == S_IDLE) begin
            if (start) begin
                steps_d   = steps;
                n_start_d = n_start;
                n_min_d   = n_min_eff;
                n_delta_d = n_delta;
                if (steps == '0) begin
                    done_d = 1'b1;
                end else begin
                    n_d        = n_start;
                    dv_d       = 1'b1;
                    step_cnt_d = '0;
                    ramp_cnt_d = '0;
                    state_d    = ((n_delta == '0) || (n_start == n_min_eff)) ? S_CRUISE : S_ACCEL;
                end
            end
        end else begin
            if (step_ev) begin
                step_cnt_d = step_cnt_q + CNT'(1);
                rem        = steps_q - step_cnt_d;
                if (rem == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if ((state_q != S_DECEL) && (rem <= ramp_cnt_q)) begin
                    // Only as many steps left as were spent accelerating.
                    state_d = S_DECEL;
                    n_d     = up_clamp(n_q, n_delta_q, n_start_q);
                end else if (state_q == S_ACCEL) begin
                    if (n_dn <= n_min_q) begin
                        n_d     = n_min_q;
                        state_d = S_CRUISE;
                    end else begin
                        n_d = n_dn;
                    end
                    ramp_cnt_d = ramp_cnt_q + CNT'(1);
                end else if (state_q == S_DECEL) begin
                    n_d = up_clamp(n_q, n_delta_q, n_start_q);
                end
            end

            // Abort acts on the post-step counters so a coincident step is
            // counted first. Stopping takes as many steps as the ramp so far.
            if (abort && (state_d != S_IDLE)) begin
                target = {1'b0, step_cnt_d} + {1'b0, ramp_cnt_d};
                if (ramp_cnt_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (state_d != S_DECEL) begin
                    state_d = S_DECEL;
                    steps_d = target[CNT-1:0];
                    n_d     = up_clamp(n_d, n_delta_q, n_start_q);
                end else if (target < {1'b0, steps_q}) begin
                    steps_d = target[CNT-1:0];
                end
            end

            dv_d = (n_d != n_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            dv_q       <= 1'b0;
            done_q     <= 1'b0;
            step_cnt_q <= '0;
            ramp_cnt_q <= '0;
            steps_q    <= '0;
            n_start_q  <= '0;
            n_min_q    <= '0;
            n_delta_q  <= '0;
            step_d1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            dv_q       <= dv_d;
            done_q     <= done_d;
            step_cnt_q <= step_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            steps_q    <= steps_d;
            n_start_q  <= n_start_d;
            n_min_q    <= n_min_d;
            n_delta_q  <= n_delta_d;
            step_d1_q  <= drv_step;
        end
    end

    assign N         = n_q;
    assign d_v       = dv_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign drv_en_SM = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sm_ramp_ctrl.sv
// Bench for sm_ramp_ctrl: directed profile scenarios followed by randomized
// moves, all checked against a closed-form model of the speed profile.

module tb_sm_ramp_ctrl;
  localparam int SIZE = 16;
  localparam int CNT  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [SIZE-1:0] n_start = '0;
  logic [SIZE-1:0] n_min = '0;
  logic [SIZE-1:0] n_delta = '0;
  logic [CNT-1:0]  steps = '0;
  logic            drv_step = 1'b0;
  logic [SIZE-1:0] N;
  logic            d_v;
  logic            drv_en_SM;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [SIZE-1:0] exp_q[$];

  sm_ramp_ctrl #(.SIZE(SIZE), .CNT(CNT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_start(n_start), .n_min(n_min), .n_delta(n_delta), .steps(steps),
    .drv_step(drv_step), .N(N), .d_v(d_v), .drv_en_SM(drv_en_SM),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---- clock / reset -------------------------------------------------
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---- scoreboard ----------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] next_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  // ---- reference model -----------------------------------------------
  // Period after step k of an uninterrupted move:
  //   A     = accel steps needed = ceil((n_start - n_min_eff) / n_delta)
  //   k_dec = first step k with (S - k) <= min(k-1, A)
  //   k < k_dec : max(n_start - min(k, A) * n_delta, n_min_eff)
  //   k >= k_dec: previous + n_delta, capped at n_start
  // An abort after step a (before k_dec) stops over r = min(a, A) steps:
  // one immediate slow-down, then r-1 more, finishing on step a + r.
  task automatic build_model(input int s, input int ns, input int nm_in, input int d,
                             input int a, output int n_steps, output bit done_on_step,
                             output bit abort_live);
    int nm, acc, k_dec, cur, lvl, r, last;
    exp_q.delete();
    nm    = (nm_in < ns) ? nm_in : ns;
    acc   = (d == 0 || ns == nm) ? 0 : (ns - nm + d - 1) / d;
    k_dec = s;
    for (int k = s - 1; k >= 1; k--)
      if (s - k <= ((k - 1 < acc) ? k - 1 : acc)) k_dec = k;
    abort_live = (a >= 0) && (a < s) && (a < k_dec);
    r          = abort_live ? ((a < acc) ? a : acc) : 0;
    cur = ns;
    exp_q.push_back(ns[SIZE-1:0]);
    last = abort_live ? a : s - 1;
    for (int k = 1; k <= last; k++) begin
      if (k < k_dec) begin
        lvl = ns - ((k < acc) ? k : acc) * d;
        cur = (lvl < nm) ? nm : lvl;
      end else begin
        cur = (cur + d > ns) ? ns : cur + d;
      end
      exp_q.push_back(cur[SIZE-1:0]);
    end
    for (int i = 0; i < r; i++) begin
      cur = (cur + d > ns) ? ns : cur + d;
      exp_q.push_back(cur[SIZE-1:0]);
    end
    n_steps      = abort_live ? a + r : s;
    done_on_step = !(abort_live && r == 0);
  endtask

  // ---- driver --------------------------------------------------------
  task automatic do_abort(input bit live, input bit done_now, inout logic [SIZE-1:0] prev);
    logic [SIZE-1:0] e;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (live && done_now) begin
      chk("abort_done", done, 1);
      chk("abort_busy", busy, 0);
      chk("abort_en", drv_en_SM, 0);
      tick();
      chk("abort_done_1cyc", done, 0);
    end else if (live) begin
      e = next_exp();
      chk("abort_N", N, e);
      chk("abort_dv", d_v, e != prev);
      chk("abort_busy", busy, 1);
      prev = e;
    end else begin
      chk("abort_ignored_dv", d_v, 0);
    end
  endtask

  task automatic run_move(input int s, input int ns, input int nm, input int d,
                          input int a, input bit restart_busy);
    int n_steps;
    bit done_on_step, live;
    logic [SIZE-1:0] prev, e;
    build_model(s, ns, nm, d, a, n_steps, done_on_step, live);
    steps = s[CNT-1:0]; n_start = ns[SIZE-1:0]; n_min = nm[SIZE-1:0]; n_delta = d[SIZE-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    if (s == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_en", drv_en_SM, 0);
      chk("zero_dv", d_v, 0);
      tick();
      chk("zero_done_1cyc", done, 0);
      chk("zero_dv2", d_v, 0);
      return;
    end
    e = next_exp();
    chk("start_N", N, e);
    chk("start_dv", d_v, 1);
    chk("start_busy", busy, 1);
    chk("start_en", drv_en_SM, 1);
    prev = e;
    tick();
    chk("start_dv_1cyc", d_v, 0);
    if (a == 0) do_abort(live, !done_on_step, prev);
    for (int k = 1; k <= n_steps; k++) begin
      drv_step = 1'b1;
      tick();
      if (k == n_steps && done_on_step) begin
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_en", drv_en_SM, 0);
        chk("end_dv", d_v, 0);
        chk("end_N", N, prev);
      end else begin
        e = next_exp();
        chk("step_N", N, e);
        chk("step_dv", d_v, e != prev);
        chk("step_busy", busy, 1);
        prev = e;
      end
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        tick();
        chk("hold_dv", d_v, 0);
      end
      drv_step = 1'b0;
      tick();
      chk("gap_dv", d_v, 0);
      chk("gap_done", done, 0);
      repeat ($urandom_range(0, 2)) tick();
      if (restart_busy && k == 1) begin
        n_start = 16'd7; steps = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_ignored_dv", d_v, 0);
        chk("restart_ignored_busy", busy, 1);
      end
      if (k == a) do_abort(live, !done_on_step, prev);
    end
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // ---- stimulus ------------------------------------------------------
  initial begin
    int s, ns, nm, d, a;
    repeat (2) tick();
    chk("rst_N", N, 0);
    chk("rst_dv", d_v, 0);
    chk("rst_en", drv_en_SM, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);
    chk("idle_abort_dv", d_v, 0);

    run_move(10, 100, 40, 20, -1, 1'b0);
    run_move(3, 100, 40, 20, -1, 1'b0);
    run_move(0, 100, 40, 20, -1, 1'b0);
    run_move(5, 100, 40, 0, -1, 1'b0);
    run_move(5, 100, 150, 20, -1, 1'b0);
    run_move(10, 100, 40, 20, 4, 1'b1);
    run_move(1, 100, 40, 20, -1, 1'b0);
    run_move(8, 50, 10, 80, -1, 1'b0);
    run_move(6, 65535, 0, 65535, -1, 1'b0);
    run_move(20, 65535, 65000, 300, -1, 1'b0);
    run_move(10, 100, 40, 20, 0, 1'b0);

    // Reset in the middle of a cruise, then a fresh move.
    steps = 16'd10; n_start = 16'd100; n_min = 16'd40; n_delta = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      drv_step = 1'b1; tick();
      drv_step = 1'b0; tick();
    end
    chk("pre_rst_N", N, 40);
    rst = 1'b1;
    tick();
    chk("mid_rst_N", N, 0);
    chk("mid_rst_dv", d_v, 0);
    chk("mid_rst_en", drv_en_SM, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    tick();
    run_move(10, 100, 40, 20, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      s  = $urandom_range(0, 30);
      ns = $urandom_range(20, 200);
      nm = $urandom_range(0, 220);
      d  = $urandom_range(0, 60);
      a  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, s) : -1;
      run_move(s, ns, nm, d, a, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
